// File: rtl/axi_data_gen_sched.sv
// ---------------------------------------------------------------------------
// axi_data_gen_sched
// Round-robin scheduler that shares one axi_data_gen between N_REQ requesters.
// A grant latches the winner's id and byte length, and the scheduler issues a
// single start/length command to the generator. It then watches the
// generator's AXI-Stream handshake. At the end of the burst it pulses a
// per-requester done, together with any error flag.
//
// Optional feature macro: AXI_GEN_SCHED_TIMEOUT_EN
//   defined   -> RUN is bounded by a watchdog of TIMEOUT_CYC cycles. A burst
//                aborted by the watchdog is reported through o_err_timeout.
//   undefined -> there is no watchdog, and o_err_timeout is constant 0.
// ---------------------------------------------------------------------------
module axi_data_gen_sched #(
    parameter int N_REQ       = 4,
    parameter int LEN_W       = 10,
    parameter int DATA_WIDTH  = 64,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           i_req,
    input  logic [N_REQ*LEN_W-1:0]     i_len,
    output logic [N_REQ-1:0]           o_grant,
    output logic [N_REQ-1:0]           o_done,
    output logic                       o_gen_start,
    output logic [LEN_W-1:0]           o_gen_length,
    input  logic                       i_gen_valid,
    input  logic                       i_gen_ready,
    input  logic                       i_gen_last,
    output logic                       o_busy,
    output logic [$clog2(N_REQ)-1:0]   o_active_id,
    output logic                       o_err_len,
    output logic                       o_err_timeout
);

    localparam int ID_W   = $clog2(N_REQ);
    localparam int BPB    = DATA_WIDTH / 8;
    localparam int BPB_SH = $clog2(BPB);
    localparam int CNT_W  = LEN_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    ptr_q;
    logic [ID_W-1:0]    id_q;
    logic [LEN_W-1:0]   len_q;
    logic [CNT_W-1:0]   beat_q;
    logic               err_len_q;

    // Arbitration results (valid only while in IDLE).
    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic [ID_W:0]      win_sum;
    logic [ID_W-1:0]    winner;
    logic [LEN_W-1:0]   win_len;
    logic               found;

    // Handshake monitor and length bookkeeping.
    logic               beat_hs;
    logic               last_hs;
    logic [LEN_W:0]     exp_beats;
    logic [CNT_W:0]     beat_inc;
    logic               timeout_hit;
    logic               err_to_flag;

    assign beat_hs   = i_gen_valid & i_gen_ready;
    assign last_hs   = beat_hs & i_gen_last;
    // Ceiling of bytes / bytes-per-beat. The extra bit keeps the carry when len is near full scale.
    assign exp_beats = ({1'b0, len_q} + (LEN_W+1)'(BPB-1)) >> BPB_SH;
    assign beat_inc  = {1'b0, beat_q} + (CNT_W+1)'(1);

    // Round-robin pick: rotate the request vector so ptr sits at bit 0, take the first set bit, then un-rotate.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path can leave it unassigned and imply a latch.
        req_dbl = {i_req, i_req};
        req_rot = req_dbl[N_REQ-1:0];
        found   = 1'b0;
        win_sum = '0;
        winner  = '0;
        win_len = '0;
        req_rot = N_REQ'(req_dbl >> ptr_q);
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && req_rot[k]) begin
                found   = 1'b1;
                win_sum = {1'b0, ptr_q} + (ID_W+1)'(k);
            end
        end
        if (win_sum >= (ID_W+1)'(N_REQ)) begin
            win_sum = win_sum - (ID_W+1)'(N_REQ);
        end
        winner = win_sum[ID_W-1:0];
        for (int k = 0; k < N_REQ; k++) begin
            if (ID_W'(k) == winner) begin
                win_len = i_len[k*LEN_W +: LEN_W];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: state and datapath registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state and decoded outputs.
    always_comb begin
        state_d       = state_q;
        o_grant       = '0;
        o_done        = '0;
        o_gen_start   = 1'b0;
        o_busy        = 1'b0;
        o_err_len     = 1'b0;
        o_err_timeout = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                o_grant[id_q] = 1'b1;
                o_busy        = 1'b1;
                // A zero-length request never reaches the generator.
                o_gen_start   = (len_q != '0);
                state_d       = (len_q == '0) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                o_busy = 1'b1;
                if (last_hs) begin
                    state_d = ST_DONE;
                end else if (timeout_hit) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                o_done[id_q]  = 1'b1;
                o_busy        = 1'b1;
                o_err_len     = err_len_q;
                o_err_timeout = err_to_flag;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Burst context: winner latch, beat counting, length check and pointer advance.
    always_ff @(posedge clk) begin
        // NOTE: the reset is synchronous and clears every register. This block has no storage array to exempt.
        if (!rst_n) begin
            ptr_q     <= '0;
            id_q      <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            err_len_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (found) begin
                        id_q  <= winner;
                        len_q <= win_len;
                    end
                end
                ST_START: begin
                    beat_q    <= '0;
                    err_len_q <= 1'b0;
                end
                ST_RUN: begin
                    // The counter saturates rather than wrapping, so an overlong burst still mismatches.
                    if (beat_hs && (beat_q != '1)) begin
                        beat_q <= beat_inc[CNT_W-1:0];
                    end
                    if (last_hs) begin
                        err_len_q <= (beat_inc != {1'b0, exp_beats});
                    end
                end
                ST_DONE: begin
                    ptr_q <= (id_q == ID_W'(N_REQ-1)) ? '0 : id_q + ID_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign o_gen_length = len_q;
    assign o_active_id  = id_q;

`ifdef AXI_GEN_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] wd_q;
    logic            err_to_q;

    // The watchdog expires on the RUN cycle that would make the count equal TIMEOUT_CYC.
    assign timeout_hit = ((wd_q + WD_W'(1)) == WD_W'(TIMEOUT_CYC));
    assign err_to_flag = err_to_q;

    // Watchdog counter and timeout flag. A real last beat on the expiry cycle takes priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_q     <= '0;
            err_to_q <= 1'b0;
        end else begin
            case (state_q)
                ST_START: begin
                    wd_q     <= '0;
                    err_to_q <= 1'b0;
                end
                ST_RUN: begin
                    wd_q <= wd_q + WD_W'(1);
                    if (!last_hs && timeout_hit) begin
                        err_to_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
`else
    // Keeps the parameter list the same in both builds. The watchdog limit has no effect in this build.
    localparam int unused_timeout_cyc = TIMEOUT_CYC;

    assign timeout_hit = 1'b0;
    assign err_to_flag = 1'b0;
`endif

endmodule
